dm_run_ctrl: RTL and testbench

Single-hart halt/resume controller for the debug module.
- Turns dmcontrol haltreq (level) and resumereq_w1 (pulse) into a debug-request handshake with the core.
- Tracks the halted, running, resumeack and havereset status that dmstatus reports.
- Tells the abstract-command engine when register access is legal, and defers resume while a command is in flight.

---
 rtl/dm_run_ctrl_if.sv | 37 +++
 rtl/dm_run_ctrl.sv | 150 +++++++++++++++
 tb/tb_dm_run_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dm_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dm_run_ctrl_if
//  Brief    : Request/status bundle between the debug module, the core and
//             the halt/resume controller.
//  Revision : 1.0
// ============================================================================
interface dm_run_ctrl_if;
   logic haltreq;
   logic resumereq_w1;
   logic ackhavereset_w1;
   logic ndmreset;
   logic cmd_busy;
   logic core_halted;
   logic dbg_halt_req;
   logic dbg_resume_req;
   logic allhalted;
   logic allrunning;
   logic allresumeack;
   logic anyhavereset;
   logic cmd_allowed;
   logic halt_timeout;

   // Drives requests and core status, observes the controller outputs.
   modport master (
      output haltreq, resumereq_w1, ackhavereset_w1, ndmreset, cmd_busy, core_halted,
      input  dbg_halt_req, dbg_resume_req, allhalted, allrunning, allresumeack,
             anyhavereset, cmd_allowed, halt_timeout
   );

   modport slave (
      input  haltreq, resumereq_w1, ackhavereset_w1, ndmreset, cmd_busy, core_halted,
      output dbg_halt_req, dbg_resume_req, allhalted, allrunning, allresumeack,
             anyhavereset, cmd_allowed, halt_timeout
   );
endinterface
`default_nettype wire

// File: rtl/dm_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dm_run_ctrl
//  Brief    : Single-hart halt/resume controller with dmstatus tracking.
//             Define DM_HALT_TIMEOUT_EN to build the acknowledge timeout.
//  Revision : 1.0
// ============================================================================
module dm_run_ctrl #(
   parameter int HALT_TIMEOUT = 1024,
   parameter int CNT_W        = 16
) (
   input  wire logic    sys_clk,
   input  wire logic    sys_rst,
   dm_run_ctrl_if.slave bus
);

   localparam logic [1:0] c_ST_RUN      = 2'd0;
   localparam logic [1:0] c_ST_HALTING  = 2'd1;
   localparam logic [1:0] c_ST_HALTED   = 2'd2;
   localparam logic [1:0] c_ST_RESUMING = 2'd3;

   logic [1:0] state_q, state_d;
   logic       resume_pending_q, resume_pending_d;
   logic       allresumeack_q, allresumeack_d;
   logic       anyhavereset_q, anyhavereset_d;
   logic       dbg_halt_req_q, dbg_resume_req_q;
   logic       allhalted_q, allrunning_q, cmd_allowed_q;
   logic       w_resume_go;

   // A resume may only launch once no command is in flight and halt is not requested.
   assign w_resume_go = (bus.resumereq_w1 | resume_pending_q) & ~bus.cmd_busy & ~bus.haltreq;

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_RUN: begin
            if (bus.core_halted)  state_d = c_ST_HALTED;
            else if (bus.haltreq) state_d = c_ST_HALTING;
         end
         c_ST_HALTING: begin
            if (bus.core_halted)   state_d = c_ST_HALTED;
            else if (!bus.haltreq) state_d = c_ST_RUN;
         end
         c_ST_HALTED: begin
            if (w_resume_go)           state_d = c_ST_RESUMING;
            else if (!bus.core_halted) state_d = c_ST_RUN;
         end
         c_ST_RESUMING: begin
            if (!bus.core_halted) state_d = c_ST_RUN;
         end
         default: state_d = c_ST_RUN;
      endcase
   end

   always_comb begin
      resume_pending_d = resume_pending_q;
      if (state_q != c_ST_HALTED || state_d != c_ST_HALTED)
         resume_pending_d = 1'b0;
      else if (bus.resumereq_w1 && bus.cmd_busy && !bus.haltreq)
         resume_pending_d = 1'b1;
   end

   always_comb begin
      allresumeack_d = allresumeack_q;
      if (state_q == c_ST_HALTED && state_d == c_ST_RESUMING)
         allresumeack_d = 1'b0;
      else if (state_q == c_ST_RESUMING && state_d == c_ST_RUN)
         allresumeack_d = 1'b1;
   end

   // A reset arriving together with its acknowledge must not be lost.
   always_comb begin
      anyhavereset_d = anyhavereset_q;
      if (bus.ndmreset)             anyhavereset_d = 1'b1;
      else if (bus.ackhavereset_w1) anyhavereset_d = 1'b0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q          <= c_ST_RUN;
         resume_pending_q <= 1'b0;
         allresumeack_q   <= 1'b0;
         anyhavereset_q   <= 1'b1;
         dbg_halt_req_q   <= 1'b0;
         dbg_resume_req_q <= 1'b0;
         allhalted_q      <= 1'b0;
         allrunning_q     <= 1'b1;
         cmd_allowed_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         resume_pending_q <= resume_pending_d;
         allresumeack_q   <= allresumeack_d;
         anyhavereset_q   <= anyhavereset_d;
         dbg_halt_req_q   <= (state_d == c_ST_HALTING);
         dbg_resume_req_q <= (state_d == c_ST_RESUMING);
         allhalted_q      <= (state_d == c_ST_HALTED);
         allrunning_q     <= (state_d == c_ST_RUN) || (state_d == c_ST_HALTING);
         cmd_allowed_q    <= (state_d == c_ST_HALTED);
      end
   end

`ifdef DM_HALT_TIMEOUT_EN
   localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(HALT_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halt_timeout_q, halt_timeout_d;
   logic             w_waiting_d, w_waiting_q;

   assign w_waiting_d = (state_d == c_ST_HALTING) || (state_d == c_ST_RESUMING);
   assign w_waiting_q = (state_q == c_ST_HALTING) || (state_q == c_ST_RESUMING);

   always_comb begin
      cnt_d = cnt_q;
      if (w_waiting_d && state_d != state_q)
         cnt_d = '0;
      else if (w_waiting_q && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + 1'b1;
   end

   always_comb begin
      halt_timeout_d = halt_timeout_q;
      if (w_waiting_d && cnt_d == c_LIMIT)
         halt_timeout_d = 1'b1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q          <= '0;
         halt_timeout_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         halt_timeout_q <= halt_timeout_d;
      end
   end

   assign bus.halt_timeout = halt_timeout_q;
`else
   assign bus.halt_timeout = 1'b0;
`endif

   assign bus.dbg_halt_req   = dbg_halt_req_q;
   assign bus.dbg_resume_req = dbg_resume_req_q;
   assign bus.allhalted      = allhalted_q;
   assign bus.allrunning     = allrunning_q;
   assign bus.allresumeack   = allresumeack_q;
   assign bus.anyhavereset   = anyhavereset_q;
   assign bus.cmd_allowed    = cmd_allowed_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_run_ctrl
//  Brief    : Directed-vector bench for the halt/resume controller.
//  Revision : 1.0
// ============================================================================
module tb_dm_run_ctrl;

   logic sys_clk;
   logic sys_rst;
   int   n_chk;
   int   n_pass;

   dm_run_ctrl_if u_if ();

   dm_run_ctrl #(
      .HALT_TIMEOUT (8),
      .CNT_W        (16)
   ) u_dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (u_if)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      sys_rst = 1'b1;
      u_if.haltreq         = 1'b0;
      u_if.resumereq_w1    = 1'b0;
      u_if.ackhavereset_w1 = 1'b0;
      u_if.ndmreset        = 1'b0;
      u_if.cmd_busy        = 1'b0;
      u_if.core_halted     = 1'b0;
      tick();
      tick();

      chk("rst_halt_req",    32'(u_if.dbg_halt_req),   32'd0);
      chk("rst_resume_req",  32'(u_if.dbg_resume_req), 32'd0);
      chk("rst_allhalted",   32'(u_if.allhalted),      32'd0);
      chk("rst_allrunning",  32'(u_if.allrunning),     32'd1);
      chk("rst_resumeack",   32'(u_if.allresumeack),   32'd0);
      chk("rst_havereset",   32'(u_if.anyhavereset),   32'd1);
      chk("rst_cmd_allowed", 32'(u_if.cmd_allowed),    32'd0);
      chk("rst_timeout",     32'(u_if.halt_timeout),   32'd0);
      sys_rst = 1'b0;
      tick();

      // Halt handshake: haltreq in cycle 0, core acknowledges in cycle 3.
      u_if.haltreq = 1'b1;
      tick();
      chk("hs_c1_halt_req",  32'(u_if.dbg_halt_req), 32'd1);
      chk("hs_c1_running",   32'(u_if.allrunning),   32'd1);
      chk("hs_c1_halted",    32'(u_if.allhalted),    32'd0);
      tick();
      chk("hs_c2_halt_req",  32'(u_if.dbg_halt_req), 32'd1);
      tick();
      chk("hs_c3_halt_req",  32'(u_if.dbg_halt_req), 32'd1);
      u_if.core_halted = 1'b1;
      tick();
      chk("hs_c4_halt_req",  32'(u_if.dbg_halt_req), 32'd0);
      chk("hs_c4_halted",    32'(u_if.allhalted),    32'd1);
      chk("hs_c4_cmd_ok",    32'(u_if.cmd_allowed),  32'd1);
      chk("hs_c4_running",   32'(u_if.allrunning),   32'd0);

      // Halt wins over a coincident resume.
      u_if.resumereq_w1 = 1'b1;
      tick();
      u_if.resumereq_w1 = 1'b0;
      chk("pri_resume_req",  32'(u_if.dbg_resume_req), 32'd0);
      chk("pri_halted",      32'(u_if.allhalted),      32'd1);
      chk("pri_resumeack",   32'(u_if.allresumeack),   32'd0);
      tick();
      chk("pri_resume_req2", 32'(u_if.dbg_resume_req), 32'd0);
      u_if.haltreq = 1'b0;
      tick();
      chk("pri_still_halted", 32'(u_if.allhalted), 32'd1);

      // Resume: pulse, core leaves debug mode two cycles later.
      u_if.resumereq_w1 = 1'b1;
      tick();
      u_if.resumereq_w1 = 1'b0;
      chk("rs_r1_resume_req", 32'(u_if.dbg_resume_req), 32'd1);
      chk("rs_r1_cmd_ok",     32'(u_if.cmd_allowed),    32'd0);
      chk("rs_r1_halted",     32'(u_if.allhalted),      32'd0);
      chk("rs_r1_running",    32'(u_if.allrunning),     32'd0);
      tick();
      chk("rs_r2_resume_req", 32'(u_if.dbg_resume_req), 32'd1);
      u_if.core_halted = 1'b0;
      tick();
      chk("rs_r3_resume_req", 32'(u_if.dbg_resume_req), 32'd0);
      chk("rs_r3_resumeack",  32'(u_if.allresumeack),   32'd1);
      chk("rs_r3_running",    32'(u_if.allrunning),     32'd1);
      chk("rs_r3_halted",     32'(u_if.allhalted),      32'd0);

      // Cancelled halt request, then a self-halt.
      u_if.haltreq = 1'b1;
      tick();
      chk("cx_c1_halt_req", 32'(u_if.dbg_halt_req), 32'd1);
      tick();
      chk("cx_c2_halt_req", 32'(u_if.dbg_halt_req), 32'd1);
      u_if.haltreq = 1'b0;
      tick();
      chk("cx_halt_req",    32'(u_if.dbg_halt_req), 32'd0);
      chk("cx_running",     32'(u_if.allrunning),   32'd1);
      u_if.core_halted = 1'b1;
      tick();
      chk("sh_halted",      32'(u_if.allhalted),    32'd1);
      chk("sh_halt_req",    32'(u_if.dbg_halt_req), 32'd0);
      chk("sh_resumeack",   32'(u_if.allresumeack), 32'd1);

      // Deferred resume behind a busy command.
      u_if.cmd_busy = 1'b1;
      tick();
      u_if.resumereq_w1 = 1'b1;
      tick();
      u_if.resumereq_w1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("df_wait%0d_resume_req", i), 32'(u_if.dbg_resume_req), 32'd0);
         chk($sformatf("df_wait%0d_halted", i),     32'(u_if.allhalted),      32'd1);
         tick();
      end
      chk("df_pre_resume_req", 32'(u_if.dbg_resume_req), 32'd0);
      u_if.cmd_busy = 1'b0;
      tick();
      chk("df_resume_req",  32'(u_if.dbg_resume_req), 32'd1);
      chk("df_resumeack",   32'(u_if.allresumeack),   32'd0);
      u_if.core_halted = 1'b0;
      tick();
      chk("df_done_resumeack", 32'(u_if.allresumeack),   32'd1);
      chk("df_done_resume_req", 32'(u_if.dbg_resume_req), 32'd0);

      // havereset: set beats clear, clear alone works.
      u_if.ndmreset        = 1'b1;
      u_if.ackhavereset_w1 = 1'b1;
      tick();
      u_if.ndmreset        = 1'b0;
      u_if.ackhavereset_w1 = 1'b0;
      chk("hr_both",  32'(u_if.anyhavereset), 32'd1);
      u_if.ackhavereset_w1 = 1'b1;
      tick();
      u_if.ackhavereset_w1 = 1'b0;
      chk("hr_ack",   32'(u_if.anyhavereset), 32'd0);
      tick();
      chk("hr_hold",  32'(u_if.anyhavereset), 32'd0);
      u_if.ndmreset = 1'b1;
      tick();
      u_if.ndmreset = 1'b0;
      chk("hr_set",   32'(u_if.anyhavereset), 32'd1);

      // Halt request the core never acknowledges.
      u_if.haltreq = 1'b1;
      for (int i = 1; i <= 7; i++) tick();
      chk("to_c7_timeout",  32'(u_if.halt_timeout), 32'd0);
      tick();
`ifdef DM_HALT_TIMEOUT_EN
      chk("to_c8_timeout",  32'(u_if.halt_timeout), 32'd1);
`else
      chk("to_c8_timeout",  32'(u_if.halt_timeout), 32'd0);
`endif
      chk("to_c8_halt_req", 32'(u_if.dbg_halt_req), 32'd1);
      tick();
      tick();
      chk("to_hold_halt_req", 32'(u_if.dbg_halt_req), 32'd1);
      u_if.haltreq = 1'b0;
      tick();
      chk("to_cancel_running", 32'(u_if.allrunning), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
